// File: rtl/reaction_time_capture_if.sv
// Bundles the FSM-facing handshake (go/capture) with the timing and BCD
// results presented to the display stage.
interface reaction_time_capture_if #(
  parameter int WIDTH = 14
);
  logic             go;
  logic             capture;
  logic [WIDTH-1:0] elapsed;
  logic [WIDTH-1:0] capt_val;
  logic [15:0]      bcd;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output go, capture,
    input  elapsed, capt_val, bcd, busy, done, overflow
  );

  modport slave (
    input  go, capture,
    output elapsed, capt_val, bcd, busy, done, overflow
  );
endinterface

// File: rtl/reaction_time_capture.sv
// Reaction timer: counts ticks while go is high, and on capture latches the
// count and converts it to 4-digit packed BCD with a serial double-dabble.

module rtc_dabble_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module reaction_time_capture #(
  parameter int CLK_DIV   = 100000,
  parameter int WIDTH     = 14,
  parameter int MAX_COUNT = 9999
)(
  input logic               clk,
  input logic               reset,
  reaction_time_capture_if.slave bus
);
  localparam int PW   = $clog2(CLK_DIV);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int NDIG = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic                   go_d;
  logic [PW-1:0]          presc;
  logic [WIDTH-1:0]       elapsed_q;
  logic                   ovf_q;
  logic [WIDTH-1:0]       capt_q;
  logic [WIDTH-1:0]       bin_sr;
  logic [NDIG-1:0][3:0]   bcd_sr;
  logic [NDIG-1:0][3:0]   adj;
  logic [4*NDIG-1:0]      adj_flat;
  logic [4*NDIG-1:0]      nxt_bcd;
  logic [15:0]            bcd_q;
  logic [CW-1:0]          cnt;
  logic                   busy_q;
  logic                   done_q;

  // ---------------- tick timer ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_d      <= 1'b0;
      presc     <= '0;
      elapsed_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      go_d <= bus.go;
      if (bus.go && !go_d) begin
        presc     <= '0;
        elapsed_q <= '0;
        ovf_q     <= 1'b0;
      end else if (bus.go) begin
        if (presc == PW'(CLK_DIV - 1)) begin
          presc <= '0;
          // Saturate one tick after reaching MAX_COUNT; that tick flags overflow.
          if (elapsed_q == WIDTH'(MAX_COUNT)) ovf_q <= 1'b1;
          else                                elapsed_q <= elapsed_q + WIDTH'(1);
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  // ---------------- double-dabble datapath ----------------
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    rtc_dabble_digit u_dig (.d(bcd_sr[g]), .q(adj[g]));
  end

  assign adj_flat = adj;
  assign nxt_bcd  = {adj_flat[4*NDIG-2:0], bin_sr[WIDTH-1]};

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      capt_q <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
      bcd_q  <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.capture) begin
            capt_q <= elapsed_q;
            bin_sr <= elapsed_q;
            bcd_sr <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr <= nxt_bcd;
          bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt    <= cnt + CW'(1);
          // Last iteration: publish the result directly so done and bcd
          // appear together in the DONE cycle.
          if (cnt == CW'(WIDTH - 1)) begin
            bcd_q  <= nxt_bcd;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.elapsed  = elapsed_q;
  assign bus.capt_val = capt_q;
  assign bus.bcd      = bcd_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/reaction_time_capture.md
Name: reaction_time_capture

Overview:
- Downstream consumer of the FSM block's go and capture outputs.
- Measures elapsed time in ticks (1 ms at the default divider) while go is high.
- On a capture pulse, latches the running time and converts it to 4-digit packed BCD with a sequential double-dabble engine, for the display stage.
- Signals completion with a one-cycle done pulse.

Parameters:
CLK_DIV, 100000, clk cycles per tick (default gives 1 ms at 100 MHz); legal range >= 2
WIDTH, 14, width of the running and captured binary count
MAX_COUNT, 9999, saturation value of the running count (4 BCD digits)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
go  input  1  level from FSM; high = timing window open
capture  input  1  one-cycle pulse from FSM; latch time and convert
elapsed  output  WIDTH  live running count (ticks)
capt_val  output  WIDTH  binary value latched by the last accepted capture
bcd  output  16  packed BCD of capt_val, digit 3 in [15:12], digit 0 in [3:0]
busy  output  1  high while conversion is in progress
done  output  1  one-cycle pulse when bcd is updated
overflow  output  1  sticky; running count hit MAX_COUNT in the current window

Behaviour:
- Reset (async, any time, including mid-conversion): all outputs, prescaler, shift registers and FSM go to 0 / IDLE immediately. No done pulse is issued for an aborted conversion.
- Go rising edge (go=1 with registered go_d=0):
  - Prescaler and elapsed clear to 0 on that edge.
  - Overflow clears.
  - Counting starts on the next cycle.
- While go=1:
  - Prescaler counts 0..CLK_DIV-1.
  - When it wraps, elapsed increments by 1 (the tick).
  - On a tick with elapsed==MAX_COUNT, elapsed holds at MAX_COUNT and overflow sets.
- While go=0: prescaler and elapsed hold; overflow holds.
- Capture in IDLE:
  - capt_val <= elapsed as sampled at that edge, i.e. the pre-increment value if a tick occurs in the same cycle.
  - FSM -> SHIFT; busy=1 from the next cycle.
  - capture is accepted regardless of go.
- Capture while busy (SHIFT or DONE): ignored; capt_val and the conversion in progress are unaffected.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: exactly WIDTH cycles of double-dabble. Each cycle, add 3 to every BCD digit >= 5, then shift left 1 bit, bringing in the next binary MSB.
  - DONE: one cycle.
- FSM transitions: IDLE -capture-> SHIFT -(WIDTH iterations)-> DONE -> IDLE.
- In DONE:
  - bcd takes the result and done=1 for exactly that cycle; busy=1 in DONE.
  - bcd holds until the next DONE.
  - A capture in the DONE cycle is ignored.
- Latency: capture sampled at edge N -> done high in cycle N+WIDTH+1 (15 cycles at default), busy low at N+WIDTH+2.
- Arithmetic: all counts unsigned. capt_val is always <= MAX_COUNT, so every BCD digit is 0..9.

Test Plan:
- Reset with CLK_DIV=4, including assertion mid-SHIFT -> all outputs 0 at once, no done pulse; after release, FSM in IDLE and busy=0.
- Basic measurement:
  - Stimulus: go=1 for 41 cycles after the rising edge, then a capture pulse.
  - Response: capt_val=10, done exactly 15 cycles after capture, bcd=16'h0010, busy high 15 cycles.
- Saturation: CLK_DIV=2, go held for 20010+ cycles -> elapsed=9999, overflow=1; capture -> bcd=16'h9999; new go rise -> elapsed=0, overflow=0.
- Hold and restart: count to 7, drop go for 20 cycles -> elapsed stays 7; capture -> bcd=16'h0007; raise go -> elapsed=0.
- Busy collision: capture at elapsed=5, second capture 3 cycles later at elapsed=6, third capture on the DONE cycle -> single done, capt_val=5, bcd=16'h0005.
- Tick coincidence: capture on the same edge that elapsed goes 12->13 -> capt_val=12, bcd=16'h0012.
